// File: rtl/div_unit.sv
// Iterative radix-2 restoring divider for DIV/DIVU: one quotient bit per cycle,
// 32 iterations, registered {remainder, quotient} result with divide-by-zero and annul handling.
module div_unit #(
    parameter int unsigned DATA_W = 32
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start_i,
    input  logic                annul_i,
    input  logic                signed_div_i,
    input  logic [DATA_W-1:0]   opdata1_i,
    input  logic [DATA_W-1:0]   opdata2_i,
    output logic [2*DATA_W-1:0] result_o,
    output logic                ready_o
);

    typedef enum logic [1:0] {
        FREE    = 2'd0,
        BY_ZERO = 2'd1,
        ON      = 2'd2,
        END     = 2'd3
    } state_t;

    state_t              state_q, state_d;
    logic [5:0]          cnt_q, cnt_d;
    logic [2*DATA_W:0]   dividend_q, dividend_d;
    logic [DATA_W-1:0]   divisor_q, divisor_d;
    logic                q_neg_q, q_neg_d;
    logic                r_neg_q, r_neg_d;
    logic [2*DATA_W-1:0] result_q, result_d;
    logic                ready_q, ready_d;

    logic [DATA_W:0]     diff;
    logic [2*DATA_W:0]   step;
    logic [DATA_W-1:0]   mag1, mag2;
    logic [DATA_W-1:0]   quot, rem;

    assign mag1 = (signed_div_i && opdata1_i[DATA_W-1]) ? -opdata1_i : opdata1_i;
    assign mag2 = (signed_div_i && opdata2_i[DATA_W-1]) ? -opdata2_i : opdata2_i;

    // Trial subtract of the divisor from the partial remainder; the new quotient bit enters at bit 0.
    assign diff = {1'b0, dividend_q[2*DATA_W-1:DATA_W]} - {1'b0, divisor_q};
    assign step = diff[DATA_W] ? (dividend_q << 1)
                               : {diff[DATA_W-1:0], dividend_q[DATA_W-1:0], 1'b1};
    assign quot = step[DATA_W-1:0];
    assign rem  = step[2*DATA_W:DATA_W+1];

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        dividend_d = dividend_q;
        divisor_d  = divisor_q;
        q_neg_d    = q_neg_q;
        r_neg_d    = r_neg_q;
        result_d   = result_q;
        ready_d    = ready_q;
        case (state_q)
            FREE: begin
                ready_d  = 1'b0;
                result_d = '0;
                if (start_i && !annul_i) begin
                    if (opdata2_i == '0) begin
                        state_d = BY_ZERO;
                    end else begin
                        state_d    = ON;
                        cnt_d      = '0;
                        dividend_d = {{DATA_W{1'b0}}, mag1, 1'b0};
                        divisor_d  = mag2;
                        q_neg_d    = signed_div_i && (opdata1_i[DATA_W-1] ^ opdata2_i[DATA_W-1]);
                        r_neg_d    = signed_div_i && opdata1_i[DATA_W-1];
                    end
                end
            end
            BY_ZERO: begin
                state_d  = END;
                result_d = '0;
                ready_d  = 1'b1;
            end
            ON: begin
                if (annul_i) begin
                    state_d  = FREE;
                    cnt_d    = '0;
                    ready_d  = 1'b0;
                    result_d = '0;
                end else begin
                    dividend_d = step;
                    cnt_d      = cnt_q + 6'd1;
                    // Last iteration: fold the sign fix-up into the same edge so ready rises at E32.
                    if (cnt_q == 6'(DATA_W - 1)) begin
                        state_d  = END;
                        result_d = {(r_neg_q ? -rem : rem), (q_neg_q ? -quot : quot)};
                        ready_d  = 1'b1;
                    end
                end
            end
            END: begin
                if (!start_i) begin
                    state_d  = FREE;
                    ready_d  = 1'b0;
                    result_d = '0;
                end
            end
            default: state_d = FREE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= FREE;
            cnt_q      <= '0;
            dividend_q <= '0;
            divisor_q  <= '0;
            q_neg_q    <= 1'b0;
            r_neg_q    <= 1'b0;
            result_q   <= '0;
            ready_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            dividend_q <= dividend_d;
            divisor_q  <= divisor_d;
            q_neg_q    <= q_neg_d;
            r_neg_q    <= r_neg_d;
            result_q   <= result_d;
            ready_q    <= ready_d;
        end
    end

    assign result_o = result_q;
    assign ready_o  = ready_q;

endmodule

// File: tb/tb_div_unit.sv
// Scoreboard bench for div_unit: directed divisions push expected results, a monitor
// checks each rising ready_o against the queue, including the start-to-ready latency.
module tb_div_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start_i = 1'b0;
    logic        annul_i = 1'b0;
    logic        signed_div_i = 1'b0;
    logic [31:0] opdata1_i = '0;
    logic [31:0] opdata2_i = '0;
    logic [63:0] result_o;
    logic        ready_o;

    int unsigned compared = 0;
    int unsigned mismatched = 0;
    int unsigned cyc = 0;
    logic        rdy_prev = 1'b0;

    typedef struct {
        logic [63:0] res;
        int unsigned e0;
        int unsigned lat;
    } exp_t;
    exp_t sb[$];

    div_unit #(.DATA_W(32)) dut (
        .clk          (clk),
        .rst          (rst),
        .start_i      (start_i),
        .annul_i      (annul_i),
        .signed_div_i (signed_div_i),
        .opdata1_i    (opdata1_i),
        .opdata2_i    (opdata2_i),
        .result_o     (result_o),
        .ready_o      (ready_o)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: every rising ready_o must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (ready_o && !rdy_prev) begin
            if (sb.size() == 0) begin
                check("unexpected_ready", 64'(ready_o), 64'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("result", result_o, e.res);
                check("latency", 64'(cyc - e.e0), 64'(e.lat));
            end
        end
        rdy_prev = ready_o;
    end

    // mode 0: normal release of start_i; mode 1: async reset while ready_o is high.
    task automatic do_div(input logic [31:0] a, input logic [31:0] b, input logic s,
                          input logic [63:0] exp, input int unsigned lat,
                          input int unsigned hold, input int unsigned mode);
        int unsigned n;
        @(negedge clk);
        sb.push_back('{res: exp, e0: cyc + 1, lat: lat});
        opdata1_i    = a;
        opdata2_i    = b;
        signed_div_i = s;
        start_i      = 1'b1;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!ready_o && n < 40);
        if (!ready_o) begin
            check("ready_timeout", 64'(ready_o), 64'd1);
            sb.delete();
        end
        for (int unsigned i = 0; i < hold; i++) begin
            @(negedge clk);
            check("hold_ready", 64'(ready_o), 64'd1);
            check("hold_result", result_o, exp);
        end
        if (mode == 1) begin
            #2 rst = 1'b1;
            start_i = 1'b0;
            #1 check("async_rst_ready", 64'(ready_o), 64'd0);
            check("async_rst_result", result_o, 64'd0);
            @(negedge clk);
            rst = 1'b0;
        end else begin
            start_i = 1'b0;
            @(negedge clk);
            check("ready_fall", 64'(ready_o), 64'd0);
            check("result_clear", result_o, 64'd0);
        end
    endtask

    initial begin
        #3;
        check("rst_ready", 64'(ready_o), 64'd0);
        check("rst_result", result_o, 64'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;

        do_div(32'd100,        32'd7,          1'b0, {32'd2, 32'd14},                 32, 0, 0);
        do_div(32'hFFFFFFF9,   32'd2,          1'b1, {32'hFFFFFFFF, 32'hFFFFFFFD},    32, 2, 0);
        do_div(32'd5,          32'd0,          1'b0, 64'h0,                           1,  1, 0);
        do_div(32'hFFFFFFF9,   32'd0,          1'b1, 64'h0,                           1,  0, 0);
        do_div(32'h80000000,   32'hFFFFFFFF,   1'b1, {32'h0, 32'h80000000},           32, 0, 0);
        do_div(32'hFFFFFFFF,   32'd1,          1'b0, {32'h0, 32'hFFFFFFFF},           32, 0, 0);
        do_div(32'hFFFFFFFF,   32'd2,          1'b0, {32'd1, 32'h7FFFFFFF},           32, 0, 0);
        do_div(32'd7,          32'hFFFFFFFE,   1'b1, {32'd1, 32'hFFFFFFFD},           32, 0, 0);
        do_div(32'hFFFFFF9C,   32'hFFFFFFF9,   1'b1, {32'hFFFFFFFE, 32'd14},          32, 0, 0);
        do_div(32'd0,          32'd5,          1'b1, 64'h0,                           32, 0, 0);

        // Annul at iteration 10: nothing pushed, so any ready_o is flagged by the monitor.
        @(negedge clk);
        opdata1_i = 32'd1000; opdata2_i = 32'd3; signed_div_i = 1'b0; start_i = 1'b1;
        repeat (11) @(negedge clk);
        annul_i = 1'b1;
        start_i = 1'b0;
        @(negedge clk);
        annul_i = 1'b0;
        check("annul_ready", 64'(ready_o), 64'd0);
        check("annul_result", result_o, 64'd0);
        repeat (35) @(negedge clk);
        check("annul_idle_ready", 64'(ready_o), 64'd0);
        do_div(32'd50, 32'd5, 1'b0, {32'd0, 32'd10}, 32, 0, 0);

        // Reset asserted between clock edges at iteration 20.
        @(negedge clk);
        opdata1_i = 32'd1234; opdata2_i = 32'd5; signed_div_i = 1'b0; start_i = 1'b1;
        repeat (21) @(negedge clk);
        #2 rst = 1'b1;
        start_i = 1'b0;
        #1 check("midon_rst_ready", 64'(ready_o), 64'd0);
        check("midon_rst_result", result_o, 64'd0);
        @(negedge clk);
        rst = 1'b0;
        repeat (35) @(negedge clk);
        check("midon_idle_ready", 64'(ready_o), 64'd0);
        do_div(32'd1234, 32'd5, 1'b0, {32'd4, 32'd246}, 32, 0, 0);
        do_div(32'd9,    32'd2, 1'b0, {32'd1, 32'd4},   32, 1, 1);
        do_div(32'd77,   32'd10, 1'b1, {32'd7, 32'd7},  32, 0, 0);

        repeat (3) @(negedge clk);
        check("sb_drained", 64'(sb.size()), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
